// File: rtl/mprj_wb_pkg.sv
// Shared definitions for the mprj Wishbone responder: register offsets,
// STATUS bit positions and the bus FSM state type.
package mprj_wb_pkg;

    localparam logic [7:0] OFF_ID      = 8'h00;
    localparam logic [7:0] OFF_CTRL    = 8'h04;
    localparam logic [7:0] OFF_STATUS  = 8'h08;
    localparam logic [7:0] OFF_TX_DATA = 8'h0C;
    localparam logic [7:0] OFF_RX_DATA = 8'h10;
    localparam logic [7:0] OFF_SCRATCH = 8'h20;

    localparam int unsigned STAT_RX_EMPTY     = 0;
    localparam int unsigned STAT_RX_FULL      = 1;
    localparam int unsigned STAT_TX_EMPTY     = 2;
    localparam int unsigned STAT_TX_FULL      = 3;
    localparam int unsigned STAT_TX_OVF       = 4;
    localparam int unsigned STAT_RX_COUNT_LSB = 8;
    localparam int unsigned STAT_TX_COUNT_LSB = 16;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

endpackage

// File: rtl/mprj_wb_fifo.sv
// Synchronous mailbox FIFO; pushes when full and pops when empty are ignored.
module mprj_wb_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mprj_wb_responder.sv
// Wishbone classic slave with ID/CTRL/STATUS, scratch registers and TX/RX mailboxes.
// Optional registered interrupt enabled by defining MPRJ_WB_IRQ_EN.
module mprj_wb_responder
    import mprj_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FF00,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] ID_VALUE    = 32'h4D50_524A
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready,
    output logic        irq_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [5:0]  lat_word;
    logic [31:0] lat_dat;

    logic        hit, fire, wr;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [5:0]  req_word;
    logic [31:0] req_dat;
    logic [7:0]  off_w;
    logic        is_scratch;
    logic [31:0] status, rd_data;
    logic        stat_clr, tx_wr, tx_push, ovf_set, scr_wr, rx_pop, tx_pop;

    logic [31:0] scratch [8];
    logic        irq_en;
    logic        tx_ovf;

    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic [31:0]   rx_head;

    assign hit = wbs_cyc_i && wbs_stb_i &&
                 ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

    // With zero wait states the access completes straight from IDLE, so the
    // request fields come from the bus rather than the latches.
    always_comb begin
        if (state == IDLE) begin
            req_we   = wbs_we_i;
            req_sel  = wbs_sel_i;
            req_word = wbs_adr_i[7:2];
            req_dat  = wbs_dat_i;
        end else begin
            req_we   = lat_we;
            req_sel  = lat_sel;
            req_word = lat_word;
            req_dat  = lat_dat;
        end
        fire = ((state == IDLE) && hit && (WAIT_STATES == 0)) ||
               ((state == WAIT) && wbs_cyc_i && wbs_stb_i && (cnt == '0));
        off_w      = {req_word, 2'b00};
        is_scratch = (off_w[7:5] == OFF_SCRATCH[7:5]);
        wr         = fire && req_we;

        stat_clr = wr && (off_w == OFF_STATUS) && req_sel[0] && req_dat[STAT_TX_OVF];
        tx_wr    = wr && (off_w == OFF_TX_DATA) && (req_sel == 4'hF);
        tx_push  = tx_wr && !tx_full;
        ovf_set  = tx_wr && tx_full;
        scr_wr   = wr && is_scratch;
        rx_pop   = fire && !req_we && (off_w == OFF_RX_DATA) && !rx_empty;
        tx_pop   = tx_valid && tx_ready;

        status = '0;
        status[STAT_RX_EMPTY] = rx_empty;
        status[STAT_RX_FULL]  = rx_full;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_TX_OVF]   = tx_ovf;
        status[STAT_RX_COUNT_LSB +: 8] = 8'(rx_count);
        status[STAT_TX_COUNT_LSB +: 8] = 8'(tx_count);

        rd_data = '0;
        case (off_w)
            OFF_ID:      rd_data = ID_VALUE;
            OFF_CTRL:    rd_data = {31'b0, irq_en};
            OFF_STATUS:  rd_data = status;
            OFF_RX_DATA: rd_data = rx_empty ? '0 : rx_head;
            default:     if (is_scratch) rd_data = scratch[off_w[4:2]];
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_sel   <= '0;
            lat_word  <= '0;
            lat_dat   <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= fire;
            wbs_dat_o <= (fire && !req_we) ? rd_data : '0;
            case (state)
                IDLE: if (hit) begin
                    lat_we   <= wbs_we_i;
                    lat_sel  <= wbs_sel_i;
                    lat_word <= wbs_adr_i[7:2];
                    lat_dat  <= wbs_dat_i;
                    if (WAIT_STATES == 0) begin
                        state <= ACK;
                    end else begin
                        state <= WAIT;
                        cnt   <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (!(wbs_cyc_i && wbs_stb_i)) state <= IDLE;
                    else if (cnt == '0)            state <= ACK;
                    else                           cnt   <= cnt - 1'b1;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            tx_ovf <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) scratch[i] <= '0;
        end else begin
            if (ovf_set)       tx_ovf <= 1'b1;
            else if (stat_clr) tx_ovf <= 1'b0;
            if (scr_wr) begin
                for (int unsigned b = 0; b < 4; b++)
                    if (req_sel[b]) scratch[off_w[4:2]][8*b +: 8] <= req_dat[8*b +: 8];
            end
        end
    end

`ifdef MPRJ_WB_IRQ_EN
    logic ctrl_wr;
    logic irq_q;
    assign ctrl_wr = wr && (off_w == OFF_CTRL) && req_sel[0];

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= req_dat[0];
            irq_q <= irq_en && !rx_empty;
        end
    end
    assign irq_o = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    mprj_wb_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (core_clk),
        .rst_n (core_rstn),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (req_dat),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    mprj_wb_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (core_clk),
        .rst_n (core_rstn),
        .push  (rx_valid && rx_ready),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

endmodule
